// File: rtl/commit_arbiter_if.sv
// Commit bus between the execute-unit commit outputs and the commit stage.
// The arbiter uses the slave modport; whatever drives the units and sinks
// the merged stream uses the master modport.
interface commit_arbiter_if #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64
);
    localparam int LOG_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]            valid_in;
    logic [NUM_REQS-1:0][DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]            eop_in;
    logic [NUM_REQS-1:0]            ready_in;
    logic                           valid_out;
    logic [DATAW-1:0]               data_out;
    logic                           eop_out;
    logic [LOG_REQS-1:0]            sel_out;
    logic                           ready_out;

    modport master (
        output valid_in, data_in, eop_in, ready_out,
        input  ready_in, valid_out, data_out, eop_out, sel_out
    );

    modport slave (
        input  valid_in, data_in, eop_in, ready_out,
        output ready_in, valid_out, data_out, eop_out, sel_out
    );
endinterface

// File: rtl/commit_arbiter.sv
// Round-robin, packet-locked merge of per-unit commit streams onto one
// commit port, with a registered output stage and a one-entry skid buffer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_OPEN   | no packet in progress; grant goes round-robin from rr_ptr
// ST_LOCKED | a packet from lock_idx is mid-flight; only it may be granted
module commit_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64
) (
    input logic            clk,
    input logic            reset,
    commit_arbiter_if.slave bus
);
    localparam int LOG_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t         state;
    lock_state_t         state_nxt;
    logic [LOG_REQS-1:0] lock_idx;
    logic [LOG_REQS-1:0] lock_idx_nxt;
    logic [LOG_REQS-1:0] rr_ptr;
    logic [LOG_REQS-1:0] rr_ptr_nxt;
    logic [LOG_REQS-1:0] rr_ptr_inc;

    logic [LOG_REQS-1:0] grant;
    logic                grant_valid;
    logic [LOG_REQS-1:0] cand;
    int                  scan_idx;

    logic                fire;
    logic                fire_eop;
    logic [DATAW-1:0]    fire_data;

    logic                out_valid;
    logic [DATAW-1:0]    out_data;
    logic                out_eop;
    logic [LOG_REQS-1:0] out_sel;

    logic                skid_valid;
    logic [DATAW-1:0]    skid_data;
    logic                skid_eop;
    logic [LOG_REQS-1:0] skid_sel;

    // Pick the single eligible requester: the locked unit, or the first
    // valid unit scanning forward from rr_ptr with modulo wrap.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        scan_idx    = 0;
        if (state == ST_LOCKED) begin
            grant       = lock_idx;
            grant_valid = bus.valid_in[lock_idx];
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                scan_idx = int'(rr_ptr) + k;
                if (scan_idx >= NUM_REQS) begin
                    scan_idx = scan_idx - NUM_REQS;
                end
                cand = LOG_REQS'(scan_idx);
                if (!grant_valid && bus.valid_in[cand]) begin
                    grant       = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // ready_in only looks at registered state and valid_in, so ready_out
    // never reaches it combinationally; a full skid stalls every unit.
    assign fire         = grant_valid && !skid_valid && !reset;
    assign bus.ready_in = fire ? (NUM_REQS'(1) << grant) : '0;
    assign fire_data    = bus.data_in[grant];
    assign fire_eop     = bus.eop_in[grant];

    // Explicit wrap so non-power-of-two unit counts never reach an
    // out-of-range pointer.
    assign rr_ptr_inc = (int'(grant) == NUM_REQS - 1) ? '0 : grant + LOG_REQS'(1);

    // Lock and round-robin pointer follow only accepted beats; a stalled or
    // partial packet leaves rr_ptr where it was.
    always_comb begin
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        rr_ptr_nxt   = rr_ptr;
        if (fire) begin
            if (fire_eop) begin
                state_nxt  = ST_OPEN;
                rr_ptr_nxt = rr_ptr_inc;
            end else begin
                state_nxt    = ST_LOCKED;
                lock_idx_nxt = grant;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_OPEN;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Output register plus skid: a skid entry always drains into the output
    // first, and while it is occupied no new beat can fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_eop    <= 1'b0;
            out_sel    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_eop   <= 1'b0;
            skid_sel   <= '0;
        end else if (skid_valid) begin
            if (bus.ready_out) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_eop    <= skid_eop;
                out_sel    <= skid_sel;
                skid_valid <= 1'b0;
            end
        end else if (fire) begin
            if (!out_valid || bus.ready_out) begin
                out_valid <= 1'b1;
                out_data  <= fire_data;
                out_eop   <= fire_eop;
                out_sel   <= grant;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= fire_data;
                skid_eop   <= fire_eop;
                skid_sel   <= grant;
            end
        end else if (bus.ready_out) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.valid_out = out_valid;
    assign bus.data_out  = out_data;
    assign bus.eop_out   = out_eop;
    assign bus.sel_out   = out_sel;
endmodule

// File: tb/tb_commit_arbiter.sv
// Bench for commit_arbiter: directed scenarios on a 4-unit and a 3-unit
// instance, then randomized traffic against a queue-based reference model.
module tb_commit_arbiter;
    localparam int DW = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    commit_arbiter_if #(.NUM_REQS(4), .DATAW(DW)) bus4 ();
    commit_arbiter_if #(.NUM_REQS(3), .DATAW(DW)) bus3 ();

    commit_arbiter #(.NUM_REQS(4), .DATAW(DW)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    commit_arbiter #(.NUM_REQS(3), .DATAW(DW)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] d;
        logic        e;
        logic [1:0]  s;
    } beat_t;

    // reference model: beats accepted but not yet delivered (depth 2 = output + skid)
    beat_t m_q[$];
    int    m_rr;
    bit    m_lock;
    int    m_lidx;

    function automatic logic [3:0] m_ready(input logic [3:0] v);
        int u;
        if (m_q.size() >= 2) return 4'b0000;
        if (m_lock) return (((v >> m_lidx) & 4'b0001) != 4'b0000) ? (4'b0001 << m_lidx) : 4'b0000;
        for (int k = 0; k < 4; k++) begin
            u = (m_rr + k) % 4;
            if (((v >> u) & 4'b0001) != 4'b0000) return 4'b0001 << u;
        end
        return 4'b0000;
    endfunction

    function automatic void m_step(input logic [3:0] rdy, input logic [3:0] eop,
                                   input logic [3:0][63:0] d, input logic ro);
        beat_t b;
        int    g;
        g = 0;
        if (m_q.size() > 0 && ro) void'(m_q.pop_front());
        if (rdy != 4'b0000) begin
            for (int k = 0; k < 4; k++) if (((rdy >> k) & 4'b0001) != 4'b0000) g = k;
            b.d = d[g[1:0]];
            b.e = eop[g[1:0]];
            b.s = g[1:0];
            m_q.push_back(b);
            if (b.e) begin
                m_lock = 1'b0;
                m_rr   = (g + 1) % 4;
            end else begin
                m_lock = 1'b1;
                m_lidx = g;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.valid_in  = '0;
        bus4.eop_in    = '0;
        bus4.data_in   = '0;
        bus4.ready_out = 1'b1;
        bus3.valid_in  = '0;
        bus3.eop_in    = '0;
        bus3.data_in   = '0;
        bus3.ready_out = 1'b1;
    endtask

    task automatic pulse_reset();
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus4.valid_in = 4'hF;
        bus4.eop_in   = 4'hF;
        bus3.valid_in = 3'h7;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus4.ready_in !== 4'b0000) $display("FAIL reset_ready4: got %b want 0000", bus4.ready_in);
        else n_pass++;
        n_checks++;
        if (bus3.ready_in !== 3'b000) $display("FAIL reset_ready3: got %b want 000", bus3.ready_in);
        else n_pass++;
        n_checks++;
        if ({bus4.valid_out, bus4.eop_out, bus4.sel_out, bus4.data_out} !== 68'h0)
            $display("FAIL reset_outputs: got v=%b e=%b s=%0d d=%h want all zero",
                     bus4.valid_out, bus4.eop_out, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
        idle_all();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus4.valid_out !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", bus4.valid_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_beat();
        pulse_reset();
        bus4.valid_in   = 4'b0100;
        bus4.data_in[2] = 64'hA5;
        bus4.eop_in[2]  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus4.ready_in !== 4'b0100) $display("FAIL single_ready: got %b want 0100", bus4.ready_in);
        else n_pass++;
        tick();
        bus4.valid_in   = 4'b1001;
        bus4.eop_in     = 4'b1001;
        bus4.data_in    = '0;
        bus4.data_in[0] = 64'hB0;
        bus4.data_in[3] = 64'hB3;
        @(negedge clk);
        n_checks++;
        if ({bus4.valid_out, bus4.eop_out, bus4.sel_out, bus4.data_out} !== {1'b1, 1'b1, 2'd2, 64'hA5})
            $display("FAIL single_out: got v=%b e=%b s=%0d d=%h want v=1 e=1 s=2 d=a5",
                     bus4.valid_out, bus4.eop_out, bus4.sel_out, bus4.data_out);
        else n_pass++;
        n_checks++;
        if (bus4.ready_in !== 4'b1000) $display("FAIL single_rr_next: got %b want 1000", bus4.ready_in);
        else n_pass++;
        tick();
        idle_all();
        @(negedge clk);
        n_checks++;
        if ({bus4.valid_out, bus4.sel_out, bus4.data_out} !== {1'b1, 2'd3, 64'hB3})
            $display("FAIL single_follow: got v=%b s=%0d d=%h want v=1 s=3 d=b3",
                     bus4.valid_out, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        int cnt[4];
        int s;
        for (int u = 0; u < 4; u++) cnt[u] = 0;
        pulse_reset();
        bus4.valid_in = 4'hF;
        bus4.eop_in   = 4'hF;
        for (int u = 0; u < 4; u++) bus4.data_in[u[1:0]] = 64'(8'hC0 + u);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus4.ready_in !== (4'b0001 << (k % 4)))
                $display("FAIL rr_ready[%0d]: got %b want %b", k, bus4.ready_in, 4'b0001 << (k % 4));
            else n_pass++;
            if (k > 0) begin
                s = (k - 1) % 4;
                n_checks++;
                if ({bus4.valid_out, bus4.sel_out, bus4.data_out} !== {1'b1, 2'(s), 64'(8'hC0 + s)})
                    $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                             k, bus4.valid_out, bus4.sel_out, bus4.data_out, s, 8'hC0 + s);
                else n_pass++;
                if (bus4.valid_out === 1'b1) cnt[bus4.sel_out]++;
            end
            tick();
        end
        n_checks++;
        if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2)
            $display("FAIL rr_fairness: got %0d,%0d,%0d,%0d want 2,2,2,2", cnt[0], cnt[1], cnt[2], cnt[3]);
        else n_pass++;
        idle_all();
        tick();
    endtask

    task automatic test_packet_lock();
        pulse_reset();
        // unit 0 single-beat packet moves rr_ptr to 1
        bus4.valid_in   = 4'b0001;
        bus4.eop_in     = 4'b0001;
        bus4.data_in[0] = 64'h40;
        tick();
        bus4.valid_in   = 4'b0011;
        bus4.data_in[1] = 64'h51;
        bus4.eop_in[1]  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus4.ready_in !== 4'b0010) $display("FAIL lock_beat1: got %b want 0010", bus4.ready_in);
        else n_pass++;
        tick();
        bus4.valid_in = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (bus4.ready_in !== 4'b0000) $display("FAIL lock_gap: got %b want 0000", bus4.ready_in);
        else n_pass++;
        n_checks++;
        if ({bus4.valid_out, bus4.eop_out, bus4.sel_out, bus4.data_out} !== {1'b1, 1'b0, 2'd1, 64'h51})
            $display("FAIL lock_out1: got v=%b e=%b s=%0d d=%h want v=1 e=0 s=1 d=51",
                     bus4.valid_out, bus4.eop_out, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
        bus4.valid_in   = 4'b0011;
        bus4.data_in[1] = 64'h52;
        @(negedge clk);
        n_checks++;
        if ({bus4.ready_in, bus4.valid_out} !== {4'b0010, 1'b0})
            $display("FAIL lock_beat2: got ready=%b v=%b want ready=0010 v=0", bus4.ready_in, bus4.valid_out);
        else n_pass++;
        tick();
        bus4.data_in[1] = 64'h53;
        bus4.eop_in[1]  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus4.ready_in, bus4.sel_out, bus4.data_out} !== {4'b0010, 2'd1, 64'h52})
            $display("FAIL lock_beat3: got ready=%b s=%0d d=%h want ready=0010 s=1 d=52",
                     bus4.ready_in, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
        // rr_ptr is now 2: unit 0 must beat unit 1
        bus4.data_in[1] = 64'h54;
        @(negedge clk);
        n_checks++;
        if ({bus4.ready_in, bus4.eop_out, bus4.sel_out, bus4.data_out} !== {4'b0001, 1'b1, 2'd1, 64'h53})
            $display("FAIL lock_release: got ready=%b e=%b s=%0d d=%h want ready=0001 e=1 s=1 d=53",
                     bus4.ready_in, bus4.eop_out, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
        bus4.valid_in = 4'b0010;
        @(negedge clk);
        n_checks++;
        if ({bus4.ready_in, bus4.sel_out, bus4.data_out} !== {4'b0010, 2'd0, 64'h40})
            $display("FAIL lock_after: got ready=%b s=%0d d=%h want ready=0010 s=0 d=40",
                     bus4.ready_in, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0]  exp_rdy [7] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        logic [63:0] exp_d   [7] = '{64'h0, 64'h10, 64'h10, 64'h10, 64'h10, 64'h11, 64'h12};
        logic        exp_v   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        ro      [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0]  nxt;
        pulse_reset();
        nxt = 8'h10;
        for (int c = 0; c < 7; c++) begin
            bus4.ready_out  = ro[c];
            bus4.valid_in   = (nxt <= 8'h12) ? 4'b1000 : 4'b0000;
            bus4.eop_in     = 4'b1000;
            bus4.data_in[3] = 64'(nxt);
            @(negedge clk);
            n_checks++;
            if (bus4.ready_in !== exp_rdy[c])
                $display("FAIL bp_ready[%0d]: got %b want %b", c, bus4.ready_in, exp_rdy[c]);
            else n_pass++;
            n_checks++;
            if (bus4.valid_out !== exp_v[c] || (exp_v[c] && bus4.data_out !== exp_d[c]))
                $display("FAIL bp_out[%0d]: got v=%b d=%h want v=%b d=%h", c, bus4.valid_out,
                         bus4.data_out, exp_v[c], exp_d[c]);
            else n_pass++;
            if (exp_rdy[c][3]) nxt = nxt + 8'h1;
            tick();
        end
        idle_all();
        @(negedge clk);
        n_checks++;
        if (bus4.valid_out !== 1'b0) $display("FAIL bp_drained: got v=%b want 0", bus4.valid_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        pulse_reset();
        bus4.ready_out  = 1'b1;
        bus4.valid_in   = 4'b0001;
        bus4.eop_in     = 4'b0000;
        bus4.data_in[0] = 64'h77;
        tick();
        reset           = 1'b1;
        bus4.valid_in   = 4'b1000;
        bus4.eop_in     = 4'b1000;
        bus4.data_in[3] = 64'h33;
        @(negedge clk);
        n_checks++;
        if (bus4.ready_in !== 4'b0000) $display("FAIL rst_mid_ready: got %b want 0000", bus4.ready_in);
        else n_pass++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus4.valid_out, bus4.ready_in} !== {1'b0, 4'b1000})
            $display("FAIL rst_mid_clear: got v=%b ready=%b want v=0 ready=1000", bus4.valid_out, bus4.ready_in);
        else n_pass++;
        tick();
        idle_all();
        @(negedge clk);
        n_checks++;
        if ({bus4.valid_out, bus4.sel_out, bus4.data_out} !== {1'b1, 2'd3, 64'h33})
            $display("FAIL rst_mid_after: got v=%b s=%0d d=%h want v=1 s=3 d=33",
                     bus4.valid_out, bus4.sel_out, bus4.data_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int         pk_left[4];
        int         beat_left[4];
        int         seq[4];
        bit         present[4];
        int         gen_total;
        int         got_total;
        int         rdy_err;
        int         out_err;
        bit         done;
        logic [3:0] exp_rdy;
        pulse_reset();
        m_q.delete();
        m_rr = 0;
        m_lock = 1'b0;
        m_lidx = 0;
        for (int u = 0; u < 4; u++) begin
            pk_left[u] = 6;
            beat_left[u] = 0;
            seq[u] = 0;
            present[u] = 1'b0;
        end
        gen_total = 0;
        got_total = 0;
        rdy_err = 0;
        out_err = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            bus4.ready_out = ($urandom_range(0, 3) != 0);
            for (int u = 0; u < 4; u++) begin
                if (!present[u] && (beat_left[u] > 0 || pk_left[u] > 0) && $urandom_range(0, 2) != 0) begin
                    if (beat_left[u] == 0) begin
                        beat_left[u] = $urandom_range(1, 3);
                        pk_left[u]--;
                    end
                    present[u] = 1'b1;
                    bus4.valid_in[u[1:0]] = 1'b1;
                    bus4.data_in[u[1:0]]  = {32'(u), 32'(seq[u])};
                    bus4.eop_in[u[1:0]]   = (beat_left[u] == 1);
                end
            end
            @(negedge clk);
            exp_rdy = m_ready(bus4.valid_in);
            n_checks++;
            if (bus4.ready_in !== exp_rdy) begin
                if (rdy_err < 5) $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus4.ready_in, exp_rdy);
                rdy_err++;
            end else n_pass++;
            n_checks++;
            if (bus4.valid_out !== (m_q.size() != 0) ||
                (m_q.size() != 0 && {bus4.data_out, bus4.eop_out, bus4.sel_out} !== {m_q[0].d, m_q[0].e, m_q[0].s})) begin
                if (out_err < 5)
                    $display("FAIL rand_out@%0d: got v=%b d=%h e=%b s=%0d want v=%0d d=%h e=%b s=%0d",
                             cyc, bus4.valid_out, bus4.data_out, bus4.eop_out, bus4.sel_out, m_q.size() != 0,
                             (m_q.size() != 0) ? m_q[0].d : 64'h0, (m_q.size() != 0) ? m_q[0].e : 1'b0,
                             (m_q.size() != 0) ? m_q[0].s : 2'd0);
                out_err++;
            end else n_pass++;
            if (bus4.valid_out === 1'b1 && bus4.ready_out) got_total++;
            m_step(exp_rdy, bus4.eop_in, bus4.data_in, bus4.ready_out);
            tick();
            for (int u = 0; u < 4; u++) begin
                if (((exp_rdy >> u) & 4'b0001) != 4'b0000) begin
                    present[u] = 1'b0;
                    bus4.valid_in[u[1:0]] = 1'b0;
                    beat_left[u]--;
                    seq[u]++;
                    gen_total++;
                end
            end
            done = (m_q.size() == 0);
            for (int u = 0; u < 4; u++)
                if (pk_left[u] > 0 || beat_left[u] > 0 || present[u]) done = 1'b0;
        end
        n_checks++;
        if (!done) $display("FAIL rand_timeout: got unfinished traffic want all packets delivered");
        else n_pass++;
        n_checks++;
        if (got_total != gen_total) $display("FAIL rand_count: got %0d beats want %0d", got_total, gen_total);
        else n_pass++;
        idle_all();
        tick();
    endtask

    task automatic test_nonpow2();
        int s;
        pulse_reset();
        bus3.valid_in = 3'b111;
        bus3.eop_in   = 3'b111;
        for (int u = 0; u < 3; u++) bus3.data_in[u[1:0]] = 64'(8'h60 + u);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus3.ready_in !== (3'b001 << (k % 3)))
                $display("FAIL np2_ready[%0d]: got %b want %b", k, bus3.ready_in, 3'b001 << (k % 3));
            else n_pass++;
            if (k > 0) begin
                s = (k - 1) % 3;
                n_checks++;
                if ({bus3.valid_out, bus3.sel_out, bus3.data_out} !== {1'b1, 2'(s), 64'(8'h60 + s)})
                    $display("FAIL np2_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                             k, bus3.valid_out, bus3.sel_out, bus3.data_out, s, 8'h60 + s);
                else n_pass++;
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_beat();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        test_nonpow2();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
